commit_trace_fifo: RTL and testbench
====================================

# commit_trace_fifo

Retirement trace buffer for the multi-cycle MIPS core. Sits directly downstream of the masked PC/IR commit registers. On each retirement strobe it captures the retired instruction's PC, IR and sequence number into a FIFO. A debug consumer (UART dumper or testbench scoreboard) drains the FIFO through a valid/ready port. It filters the post-reset dirty sentinel and records overflow without ever stalling the core.

## Interface
- DEPTH, 16: FIFO entries; power of two, ≥2.
- PC_DIRTY, 32'h44436040: sentinel PC held by the commit registers after reset. Commits carrying this PC are discarded.
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- commit_strobe  in  1  one-cycle pulse. Asserted in a posedge cycle in which commit_pc/commit_ir already hold the retired instruction (integrator aligns it after the negedge commit-register update).
- commit_pc  in  32  retired PC.
- commit_ir  in  32  retired instruction word.
- out_ready  in  1  consumer accepts the head entry.
- clr_ovf  in  1  clears overflow flag and drop counter.
- out_valid  out  1  head entry present.
- out_pc  out  32  head PC; 0 when out_valid=0.
- out_ir  out  32  head IR; 0 when out_valid=0.
- out_seq  out  32  head sequence number; 0 when out_valid=0.
- level  out  log2(DEPTH)+1  entries stored.
- ovf  out  1  sticky: at least one commit was dropped.
- drop_cnt  out  16  dropped commits, saturating at 16'hFFFF.
- retire_cnt  out  32  accepted commits (sentinel excluded), wraps modulo 2^32.

## Operation
- Valid commit: commit_strobe=1 and commit_pc≠PC_DIRTY. Sentinel commits have no effect on any state.
- Each valid commit increments retire_cnt. This happens even when the entry is dropped, so sequence gaps expose the loss.
- Stored entry is {commit_pc, commit_ir, seq}. seq is the retire_cnt value *before* the increment, so the first commit after reset has seq=0.
- Storage is a circular buffer with wr_ptr/rd_ptr of log2(DEPTH) bits and a separate level counter. Pointers wrap DEPTH-1→0.
- Push: valid commit with level<DEPTH, or with level==DEPTH and a pop in the same cycle.
- Drop: valid commit with level==DEPTH and no pop. Sets ovf; drop_cnt increments (saturating). Existing entries are untouched.
- Pop: out_valid && out_ready. Advances rd_ptr.
- Simultaneous push and pop: level unchanged; both pointers advance.
- Pop when empty: ignored.
- Show-ahead output: out_pc/out_ir/out_seq decode combinationally from the head slot, gated to 0 when empty.
- clr_ovf: next cycle ovf=0 and drop_cnt=0.
- clr_ovf coinciding with a drop: the drop wins, giving ovf=1 and drop_cnt=1.
- Only rst clears retire_cnt and the FIFO. There is no separate flush input.

## Timing
- Reset (async assert, any phase): out_valid=0, level=0, ovf=0, drop_cnt=0, retire_cnt=0, pointers 0, outputs 0. Storage contents are don't-care.
- Reset mid-operation: all pending entries are lost. The first post-reset valid commit gets seq=0.
- Push latency: a commit at posedge N is visible on out_* after posedge N. out_valid=1 during cycle N+1 if the FIFO was empty.
- No fall-through: an empty FIFO does not present commit data in the same cycle.
- Pop at posedge N: the next head (or out_valid=0) is visible during cycle N+1.
- out_valid is a function of level only. It does not depend combinationally on out_ready.
- Throughput: one push and one pop per cycle sustained.
- The block never back-pressures the core, since there is no ready output toward it.

## Test plan
- Reset sentinel: after rst, strobe with pc=32'h44436040 → level=0, retire_cnt=0, out_valid=0.
- Basic ordering: three commits with pc=0x00400000/04/08 and ir=0x20080001/02/03, out_ready=0 → level=3, head pc=0x00400000, seq=0. Then hold out_ready=1 → pcs drain in order with seq 0,1,2, then out_valid=0.
- Overflow: DEPTH=16, 18 commits, no pops → level=16, ovf=1, drop_cnt=2, retire_cnt=18. Drain yields seq 0..15. Then clr_ovf → ovf=0, drop_cnt=0.
- Full with concurrent pop: fill to 16, then commit plus out_ready in the same cycle → no drop, level stays 16, ovf=0. The last drained seq equals 16.
- Wrap-around: 40 interleaved push/pop cycles at level 1–3 → pointers wrap at least twice, all seq values contiguous, no corruption.
- Async reset mid-stream: assert rst between clock edges with level=5 → out_valid=0 immediately. The next valid commit has seq=0.

Source files
------------

// File: rtl/commit_trace_fifo.sv
// Retirement trace buffer: captures {pc, ir, seq} on each valid commit into a
// circular FIFO, drained by a debug consumer over valid/ready. Never stalls the
// core; commits arriving while full are counted as drops instead.
module commit_trace_fifo #(
    parameter int unsigned DEPTH    = 16,
    parameter logic [31:0] PC_DIRTY = 32'h44436040
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       commit_strobe,
    input  logic [31:0]                commit_pc,
    input  logic [31:0]                commit_ir,
    input  logic                       out_ready,
    input  logic                       clr_ovf,
    output logic                       out_valid,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_ir,
    output logic [31:0]                out_seq,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       ovf,
    output logic [15:0]                drop_cnt,
    output logic [31:0]                retire_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [AW:0]   FULL_LVL = LW'(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = LW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [31:0]   mem_pc  [DEPTH];
    logic [31:0]   mem_ir  [DEPTH];
    logic [31:0]   mem_seq [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   drop_q, drop_d;
    logic [31:0]   retire_q, retire_d;

    logic commit_ok;
    logic full;
    logic pop;
    logic push;
    logic drop;

    // Classify this cycle's commit and consumer handshake.
    always_comb begin
        commit_ok = commit_strobe && (commit_pc != PC_DIRTY);
        full      = (level_q == FULL_LVL);
        out_valid = (level_q != '0);
        pop       = out_valid && out_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push      = commit_ok && (!full || pop);
        drop      = commit_ok && full && !pop;
    end

    // Next-state for pointers, level and the loss/retire counters.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;
        retire_d = retire_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        // Dropped commits still consume a sequence number so gaps are visible.
        if (commit_ok) retire_d = retire_q + 32'd1;

        // A drop coinciding with clr_ovf restarts the count at one.
        if (drop) begin
            ovf_d = 1'b1;
            if (clr_ovf)                 drop_d = 16'd1;
            else if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        end else if (clr_ovf) begin
            ovf_d  = 1'b0;
            drop_d = 16'd0;
        end
    end

    // Control state register with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= 16'd0;
            retire_q <= 32'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
            retire_q <= retire_d;
        end
    end

    // Entry storage; contents are don't-care after reset so no reset here.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr_q]  <= commit_pc;
            mem_ir[wr_ptr_q]  <= commit_ir;
            mem_seq[wr_ptr_q] <= retire_q;
        end
    end

    // Show-ahead head decode, forced to zero while empty.
    always_comb begin
        out_pc     = out_valid ? mem_pc[rd_ptr_q]  : 32'd0;
        out_ir     = out_valid ? mem_ir[rd_ptr_q]  : 32'd0;
        out_seq    = out_valid ? mem_seq[rd_ptr_q] : 32'd0;
        level      = level_q;
        ovf        = ovf_q;
        drop_cnt   = drop_q;
        retire_cnt = retire_q;
    end

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Self-checking bench for commit_trace_fifo: a queue scoreboard holds expected
// {pc, ir, seq} entries pushed as commits are driven and popped on handshakes.
module tb_commit_trace_fifo;

    localparam int unsigned DEPTH    = 16;
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [31:0] PC_DIRTY = 32'h44436040;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] seq;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          commit_strobe;
    logic [31:0]   commit_pc;
    logic [31:0]   commit_ir;
    logic          out_ready;
    logic          clr_ovf;
    logic          out_valid;
    logic [31:0]   out_pc;
    logic [31:0]   out_ir;
    logic [31:0]   out_seq;
    logic [AW:0]   level;
    logic          ovf;
    logic [15:0]   drop_cnt;
    logic [31:0]   retire_cnt;

    entry_t        sb[$];
    logic [31:0]   m_retire;
    logic          m_ovf;
    logic [15:0]   m_drop;
    logic [31:0]   last_seq;
    int            n_checks = 0;
    int            n_pass   = 0;

    commit_trace_fifo #(
        .DEPTH    (DEPTH),
        .PC_DIRTY (PC_DIRTY)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .commit_strobe (commit_strobe),
        .commit_pc     (commit_pc),
        .commit_ir     (commit_ir),
        .out_ready     (out_ready),
        .clr_ovf       (clr_ovf),
        .out_valid     (out_valid),
        .out_pc        (out_pc),
        .out_ir        (out_ir),
        .out_seq       (out_seq),
        .level         (level),
        .ovf           (ovf),
        .drop_cnt      (drop_cnt),
        .retire_cnt    (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clear_model();
        sb.delete();
        m_retire = 32'd0;
        m_ovf    = 1'b0;
        m_drop   = 16'd0;
    endtask

    // Compare all status outputs against the model.
    task automatic check_state(input string tag);
        check({tag, "_level"}, 64'(level), 64'(sb.size()));
        check({tag, "_valid"}, 64'(out_valid), 64'(sb.size() != 0));
        check({tag, "_ovf"}, 64'(ovf), 64'(m_ovf));
        check({tag, "_drop"}, 64'(drop_cnt), 64'(m_drop));
        check({tag, "_retire"}, 64'(retire_cnt), 64'(m_retire));
        if (sb.size() == 0) check({tag, "_pc_gated"}, 64'(out_pc), 64'd0);
        else check({tag, "_head_pc"}, 64'(out_pc), 64'(sb[0].pc));
    endtask

    // One clock: drive inputs, score any pop, update the model, advance past the edge.
    task automatic cycle(input logic s, input logic [31:0] pc, input logic [31:0] ir,
                         input logic rdy, input logic clr);
        entry_t e;
        bit     full, popm, valid;
        commit_strobe = s;
        commit_pc     = pc;
        commit_ir     = ir;
        out_ready     = rdy;
        clr_ovf       = clr;
        full  = (sb.size() == DEPTH);
        popm  = rdy && (sb.size() > 0);
        valid = s && (pc != PC_DIRTY);
        if (popm) begin
            e = sb.pop_front();
            check("head_pc", 64'(out_pc), 64'(e.pc));
            check("head_ir", 64'(out_ir), 64'(e.ir));
            check("head_seq", 64'(out_seq), 64'(e.seq));
            last_seq = e.seq;
        end
        if (valid && full && !popm) begin
            m_ovf  = 1'b1;
            m_drop = clr ? 16'd1 : ((m_drop == 16'hFFFF) ? m_drop : m_drop + 16'd1);
        end else begin
            if (valid) sb.push_back({pc, ir, m_retire});
            if (clr) begin
                m_ovf  = 1'b0;
                m_drop = 16'd0;
            end
        end
        if (valid) m_retire = m_retire + 32'd1;
        @(posedge clk);
        #1;
        commit_strobe = 1'b0;
        out_ready     = 1'b0;
        clr_ovf       = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic commit_n(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b1, 32'h00400000 + 32'(4 * i), 32'h20080001 + 32'(i), 1'b0, 1'b0);
    endtask

    // Drain with a cycle budget; leftover entries count as a failure.
    task automatic drain(input string tag);
        for (int i = 0; i < 2 * DEPTH + 4 && sb.size() > 0; i++)
            cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        check({tag, "_left"}, 64'(sb.size()), 64'd0);
        check({tag, "_empty"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b0;
        commit_strobe = 1'b0;
        commit_pc = 32'd0;
        commit_ir = 32'd0;
        out_ready = 1'b0;
        clr_ovf = 1'b0;
        last_seq = 32'd0;
        clear_model();
        #3;
        do_reset();
        check_state("reset");

        // Sentinel PC is filtered completely.
        cycle(1'b1, PC_DIRTY, 32'h12345678, 1'b0, 1'b0);
        check_state("sentinel");
        check("sentinel_retire", 64'(retire_cnt), 64'd0);

        // Basic ordering, no fall-through then show-ahead.
        commit_strobe = 1'b1;
        commit_pc = 32'h00400000;
        #1;
        check("no_fallthrough", 64'(out_valid), 64'd0);
        commit_n(3);
        check("basic_level", 64'(level), 64'd3);
        check("basic_head_pc", 64'(out_pc), 64'h00400000);
        check("basic_head_seq", 64'(out_seq), 64'd0);
        check_state("basic");
        drain("basic_drain");
        check("basic_last_seq", 64'(last_seq), 64'd2);

        // Overflow: 18 commits into 16 slots.
        do_reset();
        commit_n(18);
        check("ovf_level", 64'(level), 64'd16);
        check("ovf_flag", 64'(ovf), 64'd1);
        check("ovf_drop", 64'(drop_cnt), 64'd2);
        check("ovf_retire", 64'(retire_cnt), 64'd18);
        // Drop together with clr_ovf: drop wins, count restarts at one.
        cycle(1'b1, 32'h00500000, 32'hdeadbeef, 1'b0, 1'b1);
        check("clrdrop_ovf", 64'(ovf), 64'd1);
        check("clrdrop_cnt", 64'(drop_cnt), 64'd1);
        check_state("clrdrop");
        drain("ovf_drain");
        check("ovf_last_seq", 64'(last_seq), 64'd15);
        cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        check("clr_ovf", 64'(ovf), 64'd0);
        check("clr_drop", 64'(drop_cnt), 64'd0);
        check_state("clr");

        // Full with concurrent pop: no drop.
        do_reset();
        commit_n(16);
        cycle(1'b1, 32'h00600000, 32'h0000abcd, 1'b1, 1'b0);
        check("fullpop_level", 64'(level), 64'd16);
        check("fullpop_ovf", 64'(ovf), 64'd0);
        check_state("fullpop");
        drain("fullpop_drain");
        check("fullpop_last_seq", 64'(last_seq), 64'd16);

        // Wrap-around: steady push with pops holding level around 1-3.
        do_reset();
        for (int i = 0; i < 40; i++)
            cycle(1'b1, 32'h00700000 + 32'(4 * i), $urandom, sb.size() >= 2, 1'b0);
        check_state("wrap");
        drain("wrap_drain");
        check("wrap_last_seq", 64'(last_seq), 64'd39);

        // Async reset between edges with five entries pending.
        do_reset();
        commit_n(5);
        check("pre_rst_level", 64'(level), 64'd5);
        #2;
        rst = 1'b1;
        #1;
        check("async_valid", 64'(out_valid), 64'd0);
        check("async_level", 64'(level), 64'd0);
        check("async_retire", 64'(retire_cnt), 64'd0);
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1'b1, 32'h00800000, 32'h11111111, 1'b0, 1'b0);
        check("post_rst_seq", 64'(out_seq), 64'd0);
        check_state("post_rst");
        drain("post_rst_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
